// File: rtl/msdap_pkg.sv
// msdap_pkg
//   Shared constants and types for the MSDAP main sequencing controller.
//   - Load sizes for the rj and coefficient memories.
//   - Depth of the circular data memory.
//   - Length of the all-zero run that puts the controller to sleep.
//   - Address and counter widths derived from those sizes.
//   - The controller state encoding.

package msdap_pkg;

    localparam int RJ_WORDS    = 16;
    localparam int COEF_WORDS  = 512;
    localparam int DATA_DEPTH  = 256;
    localparam int SLEEP_ZEROS = 800;

    // The shared write address must reach the largest memory (coefficients).
    localparam int ADDR_W     = 9;
    localparam int DATA_AW    = $clog2(DATA_DEPTH);
    localparam int LOAD_CNT_W = $clog2(COEF_WORDS);
    localparam int ZERO_CNT_W = $clog2(SLEEP_ZEROS + 1);
    localparam int WORD_W     = 16;

    typedef enum logic [2:0] {
        INIT,
        LOAD_RJ,
        LOAD_COEF,
        WAIT_INPUT,
        WORKING,
        SLEEPING,
        CLEAR
    } ctrl_state_e;

endpackage

// File: rtl/msdap_main_ctrl_if.sv
// msdap_main_ctrl_if
//   Bundles the controller's handshake and memory-write bus.
//   Front-end / engine side -> controller:
//     Start, word_valid, word_l, word_r, compute_busy
//   Controller -> memories / engine / front end:
//     InReady, rj_we, coef_we, data_we, wr_addr, wr_data_l, wr_data_r,
//     compute_start, cur_ptr, sleep, overrun
//   Modports:
//     master - the side that supplies samples and control (front end, engine)
//     slave  - the controller itself

interface msdap_main_ctrl_if;
    import msdap_pkg::*;

    logic                Start;
    logic                word_valid;
    logic [WORD_W-1:0]   word_l;
    logic [WORD_W-1:0]   word_r;
    logic                compute_busy;

    logic                InReady;
    logic                rj_we;
    logic                coef_we;
    logic                data_we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data_l;
    logic [WORD_W-1:0]   wr_data_r;
    logic                compute_start;
    logic [DATA_AW-1:0]  cur_ptr;
    logic                sleep;
    logic                overrun;

    modport master (
        output Start, word_valid, word_l, word_r, compute_busy,
        input  InReady, rj_we, coef_we, data_we, wr_addr, wr_data_l, wr_data_r,
               compute_start, cur_ptr, sleep, overrun
    );

    modport slave (
        input  Start, word_valid, word_l, word_r, compute_busy,
        output InReady, rj_we, coef_we, data_we, wr_addr, wr_data_l, wr_data_r,
               compute_start, cur_ptr, sleep, overrun
    );

endinterface

// File: rtl/msdap_zero_detect.sv
// msdap_zero_detect
//   Counts consecutive all-zero L/R samples, saturating at SLEEP_ZEROS.
//   Only built when MSDAP_SLEEP_EN is defined.
//   Ports:
//     Sclk      in   system clock
//     Reset     in   asynchronous active-low reset
//     clear     in   synchronous clear (Start)
//     sample_en in   a sample is being accepted this cycle
//     is_zero   in   the accepted sample has word_l == 0 and word_r == 0
//     sleep_req out  this sample brings the run length up to SLEEP_ZEROS

module msdap_zero_detect
    import msdap_pkg::*;
(
    input  logic Sclk,
    input  logic Reset,
    input  logic clear,
    input  logic sample_en,
    input  logic is_zero,
    output logic sleep_req
);

    logic [ZERO_CNT_W-1:0] zero_cnt_q;
    logic [ZERO_CNT_W-1:0] zero_cnt_d;

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        sleep_req  = 1'b0;
        if (clear) begin
            zero_cnt_d = '0;
        end else if (sample_en) begin
            if (!is_zero) begin
                zero_cnt_d = '0;
            end else if (zero_cnt_q != ZERO_CNT_W'(SLEEP_ZEROS)) begin
                zero_cnt_d = zero_cnt_q + 1'b1;
                // Fires only on the transition into saturation, never while saturated.
                sleep_req  = (zero_cnt_q == ZERO_CNT_W'(SLEEP_ZEROS - 1));
            end
        end
    end

    always_ff @(posedge Sclk or negedge Reset) begin
        if (!Reset) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

endmodule

// File: rtl/msdap_main_ctrl.sv
// msdap_main_ctrl
//   Main sequencing controller for the MSDAP datapath.
//   Steers assembled L/R word pairs into rj memory, coefficient memory and
//   the circular data memory, pulses compute_start once per input sample,
//   clears data memory after Start and Reset, and sleeps on long zero runs.
//   Ports:
//     Sclk   in   system clock, rising edge
//     Reset  in   asynchronous active-low reset
//     bus    slave modport of msdap_main_ctrl_if (handshake + write bus)
//   Build option:
//     MSDAP_SLEEP_EN - when defined, builds the zero detector and the
//                      SLEEPING behaviour; otherwise sleep is tied low.

module msdap_main_ctrl
    import msdap_pkg::*;
(
    input  logic              Sclk,
    input  logic              Reset,
    msdap_main_ctrl_if.slave  bus
);

    ctrl_state_e           state_q,    state_d;
    logic [DATA_AW-1:0]    clr_cnt_q,  clr_cnt_d;
    logic [LOAD_CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [DATA_AW-1:0]    wptr_q,     wptr_d;
    logic [DATA_AW-1:0]    cur_ptr_q,  cur_ptr_d;
    logic                  overrun_q,  overrun_d;
    logic                  cfg_done_q, cfg_done_d;

    logic                  in_ready_q, in_ready_d;
    logic                  rj_we_q,    rj_we_d;
    logic                  coef_we_q,  coef_we_d;
    logic                  data_we_q,  data_we_d;
    logic                  cs_q,       cs_d;
    logic [ADDR_W-1:0]     wr_addr_q,  wr_addr_d;
    logic [WORD_W-1:0]     wr_l_q,     wr_l_d;
    logic [WORD_W-1:0]     wr_r_q,     wr_r_d;

    logic                  sample_state;
    logic                  sleep_req;
    logic                  drop_sample;

    assign sample_state = (state_q == WAIT_INPUT) || (state_q == WORKING) ||
                          (state_q == SLEEPING);

`ifdef MSDAP_SLEEP_EN
    logic word_zero;

    assign word_zero   = (bus.word_l == '0) && (bus.word_r == '0);
    // Zero samples arriving while asleep are swallowed entirely.
    assign drop_sample = (state_q == SLEEPING) && word_zero;

    msdap_zero_detect u_zero_detect (
        .Sclk      (Sclk),
        .Reset     (Reset),
        .clear     (bus.Start),
        .sample_en (bus.word_valid && sample_state && !bus.Start),
        .is_zero   (word_zero),
        .sleep_req (sleep_req)
    );

    assign bus.sleep = (state_q == SLEEPING);
`else
    assign sleep_req   = 1'b0;
    assign drop_sample = 1'b0;
    assign bus.sleep   = 1'b0;
`endif

    // State register plus all datapath and output flops.
    always_ff @(posedge Sclk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            load_cnt_q <= '0;
            wptr_q     <= '0;
            cur_ptr_q  <= '0;
            overrun_q  <= 1'b0;
            in_ready_q <= 1'b0;
            rj_we_q    <= 1'b0;
            coef_we_q  <= 1'b0;
            data_we_q  <= 1'b0;
            cs_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_l_q     <= '0;
            wr_r_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            load_cnt_q <= load_cnt_d;
            wptr_q     <= wptr_d;
            cur_ptr_q  <= cur_ptr_d;
            overrun_q  <= overrun_d;
            in_ready_q <= in_ready_d;
            rj_we_q    <= rj_we_d;
            coef_we_q  <= coef_we_d;
            data_we_q  <= data_we_d;
            cs_q       <= cs_d;
            wr_addr_q  <= wr_addr_d;
            wr_l_q     <= wr_l_d;
            wr_r_q     <= wr_r_d;
        end
    end

    // cfg_done deliberately has no reset so a Reset does not force a reload of
    // rj and coefficients; it is held while Reset is asserted.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            cfg_done_q <= cfg_done_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        load_cnt_d = load_cnt_q;
        wptr_d     = wptr_q;
        cur_ptr_d  = cur_ptr_q;
        overrun_d  = overrun_q;
        cfg_done_d = cfg_done_q;

        if (bus.Start) begin
            state_d    = INIT;
            cfg_done_d = 1'b0;
            clr_cnt_d  = '0;
            load_cnt_d = '0;
            wptr_d     = '0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                INIT, CLEAR: begin
                    // clr_cnt wraps to 0 by itself on the last sweep cycle.
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == DATA_AW'(DATA_DEPTH - 1)) begin
                        load_cnt_d = '0;
                        if ((state_q == CLEAR) && cfg_done_q) begin
                            state_d = WAIT_INPUT;
                        end else begin
                            state_d = LOAD_RJ;
                        end
                    end
                end
                LOAD_RJ: begin
                    if (bus.word_valid) begin
                        if (load_cnt_q == LOAD_CNT_W'(RJ_WORDS - 1)) begin
                            load_cnt_d = '0;
                            state_d    = LOAD_COEF;
                        end else begin
                            load_cnt_d = load_cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_COEF: begin
                    if (bus.word_valid) begin
                        if (load_cnt_q == LOAD_CNT_W'(COEF_WORDS - 1)) begin
                            load_cnt_d = '0;
                            cfg_done_d = 1'b1;
                            state_d    = WAIT_INPUT;
                        end else begin
                            load_cnt_d = load_cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_INPUT, WORKING, SLEEPING: begin
                    if (bus.word_valid) begin
                        if (bus.compute_busy) begin
                            overrun_d = 1'b1;
                        end
                        if (!drop_sample) begin
                            cur_ptr_d = wptr_q;
                            wptr_d    = wptr_q + 1'b1;
                            state_d   = sleep_req ? SLEEPING : WORKING;
                        end
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    // Registered output values. InReady follows the state one cycle late so
    // it stays low through the final write of a clear sweep.
    always_comb begin
        in_ready_d = !((state_q == INIT) || (state_q == CLEAR));
        rj_we_d    = 1'b0;
        coef_we_d  = 1'b0;
        data_we_d  = 1'b0;
        cs_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_l_d     = wr_l_q;
        wr_r_d     = wr_r_q;

        if (!bus.Start) begin
            case (state_q)
                INIT, CLEAR: begin
                    data_we_d = 1'b1;
                    wr_addr_d = ADDR_W'(clr_cnt_q);
                    wr_l_d    = '0;
                    wr_r_d    = '0;
                end
                LOAD_RJ: begin
                    if (bus.word_valid) begin
                        rj_we_d   = 1'b1;
                        wr_addr_d = ADDR_W'(load_cnt_q);
                        wr_l_d    = bus.word_l;
                        wr_r_d    = bus.word_r;
                    end
                end
                LOAD_COEF: begin
                    if (bus.word_valid) begin
                        coef_we_d = 1'b1;
                        wr_addr_d = ADDR_W'(load_cnt_q);
                        wr_l_d    = bus.word_l;
                        wr_r_d    = bus.word_r;
                    end
                end
                WAIT_INPUT, WORKING, SLEEPING: begin
                    if (bus.word_valid && !drop_sample) begin
                        data_we_d = 1'b1;
                        cs_d      = 1'b1;
                        wr_addr_d = ADDR_W'(wptr_q);
                        wr_l_d    = bus.word_l;
                        wr_r_d    = bus.word_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.InReady       = in_ready_q;
    assign bus.rj_we         = rj_we_q;
    assign bus.coef_we       = coef_we_q;
    assign bus.data_we       = data_we_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data_l     = wr_l_q;
    assign bus.wr_data_r     = wr_r_q;
    assign bus.compute_start = cs_q;
    assign bus.cur_ptr       = cur_ptr_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_msdap_main_ctrl.sv
// tb_msdap_main_ctrl
//   Scoreboard bench for msdap_main_ctrl. Stimulus pushes the write it expects
//   the controller to perform; a monitor pops and compares on every cycle the
//   controller presents a write enable or compute_start.
//   Honours MSDAP_SLEEP_EN the same way the design does.

module tb_msdap_main_ctrl;
    import msdap_pkg::*;

    typedef struct packed {
        logic        in_ready;
        logic        rj;
        logic        coef;
        logic        dat;
        logic        cs;
        logic        slp;
        logic        ovr;
        logic [7:0]  ptr;
        logic [8:0]  addr;
        logic [15:0] l;
        logic [15:0] r;
    } obs_t;

`ifdef MSDAP_SLEEP_EN
    localparam bit SLEEP_ON = 1'b1;
`else
    localparam bit SLEEP_ON = 1'b0;
`endif

    logic Sclk = 1'b0;
    logic Reset;

    msdap_main_ctrl_if bus ();

    msdap_main_ctrl dut (
        .Sclk  (Sclk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Sclk = ~Sclk;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_wptr = 0;
    int   exp_cur = 0;
    logic exp_ovr = 1'b0;
    logic exp_slp = 1'b0;

    function automatic obs_t observe();
        obs_t o;
        o.in_ready = bus.InReady;
        o.rj       = bus.rj_we;
        o.coef     = bus.coef_we;
        o.dat      = bus.data_we;
        o.cs       = bus.compute_start;
        o.slp      = bus.sleep;
        o.ovr      = bus.overrun;
        o.ptr      = bus.cur_ptr;
        o.addr     = bus.wr_addr;
        o.l        = bus.wr_data_l;
        o.r        = bus.wr_data_r;
        return o;
    endfunction

    function automatic obs_t mk(input logic ir, input logic rj, input logic coef,
                                input logic dat, input logic cs, input int addr,
                                input logic [15:0] l, input logic [15:0] r);
        obs_t e;
        e.in_ready = ir;
        e.rj       = rj;
        e.coef     = coef;
        e.dat      = dat;
        e.cs       = cs;
        e.slp      = exp_slp;
        e.ovr      = exp_ovr;
        e.ptr      = 8'(exp_cur);
        e.addr     = 9'(addr);
        e.l        = l;
        e.r        = r;
        return e;
    endfunction

    task automatic check_output(input string name, input obs_t got, input obs_t req);
        total++;
        if (got !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic check_value(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Monitor: every active write/compute cycle must match the oldest expectation.
    initial begin
        obs_t got;
        obs_t e;
        forever begin
            @(negedge Sclk);
            if (Reset === 1'b1 && (bus.rj_we || bus.coef_we || bus.data_we || bus.compute_start)) begin
                got = observe();
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got %h required none", got);
                end else begin
                    e = exp_q.pop_front();
                    check_output($sformatf("write@%0d", e.addr), got, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic [15:0] l, input logic [15:0] r);
        @(negedge Sclk);
        bus.word_valid = 1'b1;
        bus.word_l     = l;
        bus.word_r     = r;
        @(negedge Sclk);
        bus.word_valid = 1'b0;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < DATA_DEPTH; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, i, 16'h0, 16'h0));
        end
    endtask

    task automatic send_sample(input logic [15:0] l, input logic [15:0] r);
        exp_cur = exp_wptr;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, exp_wptr, l, r));
        exp_wptr = (exp_wptr + 1) % DATA_DEPTH;
        apply_stimulus(l, r);
    endtask

    task automatic load_config(input int n_coef);
        for (int i = 0; i < RJ_WORDS; i++) begin
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, i, 16'(32'hA000 + i), 16'(32'h5000 + i)));
            apply_stimulus(16'(32'hA000 + i), 16'(32'h5000 + i));
        end
        for (int i = 0; i < n_coef; i++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, i, 16'(32'hC000 + i), 16'(32'h3000 + i)));
            apply_stimulus(16'(32'hC000 + i), 16'(32'h3000 + i));
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.InReady !== 1'b1 && n < 1000) begin
            @(negedge Sclk);
            n++;
        end
        if (bus.InReady !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_ready: InReady=%b required 1 within 1000 cycles", bus.InReady);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge Sclk);
            n++;
        end
        repeat (2) @(negedge Sclk);
        check_value({name, "_pending"}, exp_q.size(), 0);
    endtask

    // Start pulse; optionally collides with a word_valid that must be ignored.
    task automatic do_start(input bit with_word);
        @(negedge Sclk);
        bus.Start = 1'b1;
        if (with_word) begin
            bus.word_valid = 1'b1;
            bus.word_l     = 16'(32'hC000 + 200);
            bus.word_r     = 16'(32'h3000 + 200);
        end
        exp_ovr  = 1'b0;
        exp_slp  = 1'b0;
        exp_wptr = 0;
        push_sweep();
        @(negedge Sclk);
        bus.Start      = 1'b0;
        bus.word_valid = 1'b0;
        @(negedge Sclk);
        check_value("inready_low_after_start", int'(bus.InReady), 0);
    endtask

    initial begin
        Reset            = 1'b0;
        bus.Start        = 1'b0;
        bus.word_valid   = 1'b0;
        bus.word_l       = '0;
        bus.word_r       = '0;
        bus.compute_busy = 1'b0;
        #3;
        check_output("reset_outputs", observe(), '0);

        // Scenario 1: release Reset together with Start, full configuration.
        @(negedge Sclk);
        Reset     = 1'b1;
        bus.Start = 1'b1;
        push_sweep();
        @(negedge Sclk);
        bus.Start = 1'b0;
        @(negedge Sclk);
        check_value("inready_low_in_init", int'(bus.InReady), 0);
        wait_ready();
        load_config(COEF_WORDS);
        drain("config");

        // Scenario 2 and 3: 4729 samples, wrapping the data pointer.
        for (int i = 0; i < 4729; i++) begin
            send_sample(16'(32'h1000 + i), 16'(32'h8000 ^ i));
        end
        drain("samples");

        @(negedge Sclk);
        Reset = 1'b0;
        #1;
        check_output("reset_mid_run_outputs", observe(), '0);
        repeat (10) @(negedge Sclk);
        Reset    = 1'b1;
        exp_wptr = 0;
        exp_cur  = 0;
        exp_ovr  = 1'b0;
        exp_slp  = 1'b0;
        push_sweep();
        wait_ready();
        send_sample(16'h1234, 16'h5678);
        drain("after_reset");
        check_value("cur_ptr_after_reset", int'(bus.cur_ptr), 0);

        // Scenario 4: long zero run.
        for (int i = 0; i < SLEEP_ZEROS; i++) begin
            exp_slp = SLEEP_ON && (i == SLEEP_ZEROS - 1);
            send_sample(16'h0, 16'h0);
        end
        drain("zero_run");
        check_value("sleep_after_zero_run", int'(bus.sleep), int'(SLEEP_ON));
        for (int i = 0; i < 50; i++) begin
            if (SLEEP_ON) apply_stimulus(16'h0, 16'h0);
            else          send_sample(16'h0, 16'h0);
        end
        drain("sleeping_zeros");
        exp_slp = 1'b0;
        send_sample(16'h0001, 16'h0000);
        drain("wake");
        check_value("sleep_after_wake", int'(bus.sleep), 0);

        // Scenario 5: overrun is sticky until Start.
        check_value("overrun_idle", int'(bus.overrun), 0);
        bus.compute_busy = 1'b1;
        exp_ovr = 1'b1;
        send_sample(16'h0BAD, 16'h0F00);
        bus.compute_busy = 1'b0;
        send_sample(16'h0C0D, 16'h0E00);
        drain("overrun");
        check_value("overrun_sticky", int'(bus.overrun), 1);
        do_start(1'b0);
        check_value("overrun_cleared", int'(bus.overrun), 0);

        // Scenario 6: Start during coefficient load restarts configuration.
        wait_ready();
        load_config(200);
        do_start(1'b1);
        wait_ready();
        load_config(COEF_WORDS);
        send_sample(16'h4321, 16'h8765);
        drain("reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
